// File: rtl/fft_collect_pkg.sv
// Shared constants and FSM state type for the FFT output collector.
package fft_collect_pkg;

  localparam int unsigned N_POINTS    = 1024;
  localparam int unsigned BEATS       = N_POINTS / 2;
  localparam int unsigned STORE_BEATS = N_POINTS / 4;
  localparam int unsigned ADDR_W      = $clog2(BEATS);
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned MAG_W_DEF   = DATA_W + 1;
  localparam int unsigned CNT_W_DEF   = 16;

  typedef enum logic {
    IDLE    = 1'b0,
    CAPTURE = 1'b1
  } state_t;

endpackage

// File: rtl/fft_collect_if.sv
// FFT output stream, spectrum read port and status bundle.
interface fft_collect_if #(
  parameter int unsigned W      = fft_collect_pkg::DATA_W,
  parameter int unsigned MAG_W  = W + 1,
  parameter int unsigned CNT_W  = fft_collect_pkg::CNT_W_DEF,
  parameter int unsigned ADDR_W = fft_collect_pkg::ADDR_W
);

  logic                    next_out;
  logic signed [W-1:0]     Y0;
  logic signed [W-1:0]     Y1;
  logic signed [W-1:0]     Y2;
  logic signed [W-1:0]     Y3;
  logic [ADDR_W-1:0]       rd_addr;
  logic [MAG_W-1:0]        rd_data;
  logic                    frame_valid;
  logic                    frame_ready;
  logic [CNT_W-1:0]        frame_cnt;
  logic                    busy;
  logic                    overrun;

  modport master (
    output next_out, Y0, Y1, Y2, Y3, rd_addr,
    input  rd_data, frame_valid, frame_ready, frame_cnt, busy, overrun
  );

  modport slave (
    input  next_out, Y0, Y1, Y2, Y3, rd_addr,
    output rd_data, frame_valid, frame_ready, frame_cnt, busy, overrun
  );

endinterface

// File: rtl/fft_mag_approx.sv
// Registered magnitude estimate of one complex word.
// FFT_COLLECT_AMBM_EN selects alpha-max-beta-min instead of |re|+|im|.
module fft_mag_approx #(
  parameter int unsigned W     = 32,
  parameter int unsigned MAG_W = W + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] re,
  input  logic signed [W-1:0] im,
  output logic [MAG_W-1:0]    mag
);

  logic [W-1:0]     abs_re;
  logic [W-1:0]     abs_im;
  logic [MAG_W-1:0] mag_d;
`ifdef FFT_COLLECT_AMBM_EN
  logic [W-1:0]     big;
  logic [W-1:0]     small;
`endif

  // Two's-complement negation of the most negative value wraps to 2^(W-1),
  // which is exactly right once read as unsigned.
  always_comb begin
    abs_re = re[W-1] ? $unsigned(-re) : $unsigned(re);
    abs_im = im[W-1] ? $unsigned(-im) : $unsigned(im);
  end

`ifdef FFT_COLLECT_AMBM_EN
  always_comb begin
    big   = (abs_re >= abs_im) ? abs_re : abs_im;
    small = (abs_re >= abs_im) ? abs_im : abs_re;
    mag_d = MAG_W'(big) + MAG_W'(small >> 1);
  end
`else
  always_comb begin
    mag_d = MAG_W'(abs_re) + MAG_W'(abs_im);
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      mag <= '0;
    end else begin
      mag <= mag_d;
    end
  end

endmodule

// File: rtl/fft_out_collector.sv
// Collects one FFT frame, stores lower-half bin magnitudes in a ping-pong
// buffer and serves them on a 1-cycle read port. Option: FFT_COLLECT_AMBM_EN.
module fft_out_collector #(
  parameter int unsigned N_POINTS = fft_collect_pkg::N_POINTS,
  parameter int unsigned W        = fft_collect_pkg::DATA_W,
  parameter int unsigned MAG_W    = W + 1,
  parameter int unsigned CNT_W    = fft_collect_pkg::CNT_W_DEF
) (
  input  logic         clk,
  input  logic         reset,
  fft_collect_if.slave bus
);

  import fft_collect_pkg::*;

  localparam int unsigned N_BEATS = N_POINTS / 2;
  localparam int unsigned N_STORE = N_POINTS / 4;
  localparam int unsigned BEAT_W  = $clog2(N_BEATS);
  localparam int unsigned IDX_W   = $clog2(N_STORE);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(N_BEATS - 1);
  localparam logic [BEAT_W-1:0] STORE_LIM = BEAT_W'(N_STORE);

  state_t              state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                publish, abort, store;

  logic                wr_bank, rd_bank;
  logic                wr_en_q;
  logic [IDX_W-1:0]    wr_idx_q;
  logic                frame_valid_q, frame_ready_q, overrun_q;
  logic [CNT_W-1:0]    frame_cnt_q;
  logic [MAG_W-1:0]    rd_data_q;
  logic [MAG_W-1:0]    mag_even, mag_odd;

  // Even bins (2k) and odd bins (2k+1) live in separate arrays so each beat
  // needs only one write port per array. Index = {bank, k}.
  logic [MAG_W-1:0]    mem_even [2*N_STORE];
  logic [MAG_W-1:0]    mem_odd  [2*N_STORE];

  fft_mag_approx #(.W(W), .MAG_W(MAG_W)) u_mag_even (
    .clk   (clk),
    .reset (reset),
    .re    (bus.Y0),
    .im    (bus.Y1),
    .mag   (mag_even)
  );

  fft_mag_approx #(.W(W), .MAG_W(MAG_W)) u_mag_odd (
    .clk   (clk),
    .reset (reset),
    .re    (bus.Y2),
    .im    (bus.Y3),
    .mag   (mag_odd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    publish = 1'b0;
    abort   = 1'b0;
    store   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.next_out) begin
          state_d = CAPTURE;
          beat_d  = '0;
        end
      end
      CAPTURE: begin
        if (beat_q == LAST_BEAT) begin
          // A frame start on the final beat chains straight into the next frame.
          publish = 1'b1;
          beat_d  = '0;
          state_d = bus.next_out ? CAPTURE : IDLE;
        end else if (bus.next_out) begin
          abort  = 1'b1;
          beat_d = '0;
        end else begin
          store  = (beat_q < STORE_LIM);
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_idx_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_cnt_q   <= '0;
      overrun_q     <= 1'b0;
    end else begin
      wr_en_q       <= store;
      wr_idx_q      <= beat_q[IDX_W-1:0];
      frame_valid_q <= publish;
      if (abort) begin
        overrun_q <= 1'b1;
      end
      if (publish) begin
        rd_bank       <= wr_bank;
        wr_bank       <= ~wr_bank;
        frame_ready_q <= 1'b1;
        frame_cnt_q   <= frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_q) begin
      mem_even[{wr_bank, wr_idx_q}] <= mag_even;
      mem_odd[{wr_bank, wr_idx_q}]  <= mag_odd;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_data_q <= '0;
    end else if (bus.rd_addr[0]) begin
      rd_data_q <= mem_odd[{rd_bank, bus.rd_addr[BEAT_W-1:1]}];
    end else begin
      rd_data_q <= mem_even[{rd_bank, bus.rd_addr[BEAT_W-1:1]}];
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_ready = frame_ready_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.overrun     = overrun_q;
  assign bus.busy        = (state_q == CAPTURE);

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed self-checking bench for fft_out_collector (both magnitude builds).
module tb_fft_out_collector;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  int   fv_seen;

  logic signed [31:0] y0_a [512];
  logic signed [31:0] y1_a [512];
  logic signed [31:0] y2_a [512];
  logic signed [31:0] y3_a [512];

`ifdef FFT_COLLECT_AMBM_EN
  localparam logic [63:0] EXP_B0   = 64'd125;
  localparam logic [63:0] EXP_EXT0 = 64'h0_C000_0000;
  localparam logic [63:0] EXP_EXT1 = 64'h0_BFFF_FFFF;
`else
  localparam logic [63:0] EXP_B0   = 64'd150;
  localparam logic [63:0] EXP_EXT0 = 64'h1_0000_0000;
  localparam logic [63:0] EXP_EXT1 = 64'h0_FFFF_FFFF;
`endif

  fft_collect_if bus ();

  fft_out_collector dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_frame();
    for (int j = 0; j < 512; j++) begin
      y0_a[j] = '0; y1_a[j] = '0; y2_a[j] = '0; y3_a[j] = '0;
    end
  endtask

  task automatic idle_inputs();
    bus.next_out = 1'b0;
    bus.Y0 = '0; bus.Y1 = '0; bus.Y2 = '0; bus.Y3 = '0;
  endtask

  task automatic drive_beat(input int j);
    bus.Y0 = y0_a[j]; bus.Y1 = y1_a[j]; bus.Y2 = y2_a[j]; bus.Y3 = y3_a[j];
  endtask

  task automatic start_frame();
    bus.next_out = 1'b1;
    tick();
    bus.next_out = 1'b0;
  endtask

  task automatic run_beats(input int first, input int last_excl);
    for (int j = first; j < last_excl; j++) begin
      drive_beat(j);
      tick();
      if (bus.frame_valid) fv_seen++;
    end
  endtask

  task automatic read_bin(input int addr, output logic [63:0] val);
    bus.rd_addr = addr[8:0];
    tick();
    val = 64'(bus.rd_data);
  endtask

  // Frame body: 511 quiet beats, then the final beat must publish.
  task automatic finish_frame(input string tag, input logic chain);
    fv_seen = 0;
    run_beats(0, 511);
    check({tag, "_fv_quiet"}, 64'(fv_seen), 64'd0);
    bus.next_out = chain;
    drive_beat(511);
    tick();
    bus.next_out = 1'b0;
    check({tag, "_fv_pulse"}, 64'(bus.frame_valid), 64'd1);
  endtask

  initial begin
    logic [63:0] v;
    tests = 0;
    fails = 0;
    reset = 1'b0;
    bus.rd_addr = '0;
    idle_inputs();
    clear_frame();
    tick();
    tick();
    reset = 1'b1;
    check("rst_fv", 64'(bus.frame_valid), 64'd0);
    check("rst_ready", 64'(bus.frame_ready), 64'd0);
    check("rst_cnt", 64'(bus.frame_cnt), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_ovr", 64'(bus.overrun), 64'd0);
    check("rst_rd", 64'(bus.rd_data), 64'd0);

    // Single-beat frame
    y0_a[0] = 100; y1_a[0] = -50; y2_a[0] = -7; y3_a[0] = 0;
    start_frame();
    check("f1_busy", 64'(bus.busy), 64'd1);
    finish_frame("f1", 1'b0);
    check("f1_cnt", 64'(bus.frame_cnt), 64'd1);
    check("f1_ready", 64'(bus.frame_ready), 64'd1);
    idle_inputs();
    tick();
    check("f1_fv_drop", 64'(bus.frame_valid), 64'd0);
    check("f1_idle", 64'(bus.busy), 64'd0);
    read_bin(0, v); check("f1_bin0", v, EXP_B0);
    read_bin(1, v); check("f1_bin1", v, 64'd7);
    read_bin(5, v); check("f1_bin5", v, 64'd0);

    // Ramp: every bin 2k and 2k+1 equals k; beats >=256 must not alias in
    clear_frame();
    for (int j = 0; j < 512; j++) begin
      y0_a[j] = j; y2_a[j] = j;
    end
    start_frame();
    finish_frame("ramp", 1'b0);
    check("ramp_cnt", 64'(bus.frame_cnt), 64'd2);
    idle_inputs();
    for (int a = 0; a < 512; a++) begin
      read_bin(a, v);
      check("ramp_bin", v, 64'(a / 2));
    end

    // Back-to-back frames
    clear_frame();
    y0_a[0] = 11;
    start_frame();
    finish_frame("b2b_a", 1'b1);
    check("b2b_a_cnt", 64'(bus.frame_cnt), 64'd3);
    clear_frame();
    y0_a[0] = 22;
    bus.rd_addr = '0;
    fv_seen = 0;
    run_beats(0, 300);
    check("b2b_old_bank", 64'(bus.rd_data), 64'd11);
    run_beats(300, 511);
    check("b2b_fv_quiet", 64'(fv_seen), 64'd0);
    drive_beat(511);
    tick();
    check("b2b_b_fv", 64'(bus.frame_valid), 64'd1);
    check("b2b_b_cnt", 64'(bus.frame_cnt), 64'd4);
    check("b2b_pub_read", 64'(bus.rd_data), 64'd11);
    idle_inputs();
    tick();
    check("b2b_new_bank", 64'(bus.rd_data), 64'd22);
    check("b2b_ovr", 64'(bus.overrun), 64'd0);

    // Overrun: restart at beat 100
    clear_frame();
    y0_a[0] = 33;
    start_frame();
    fv_seen = 0;
    run_beats(0, 100);
    bus.next_out = 1'b1;
    drive_beat(100);
    tick();
    bus.next_out = 1'b0;
    check("ovr_flag", 64'(bus.overrun), 64'd1);
    check("ovr_no_pub", 64'(fv_seen + bus.frame_valid), 64'd0);
    check("ovr_busy", 64'(bus.busy), 64'd1);
    clear_frame();
    y0_a[0] = 44;
    finish_frame("ovr", 1'b0);
    check("ovr_cnt", 64'(bus.frame_cnt), 64'd5);
    idle_inputs();
    read_bin(0, v); check("ovr_bin0", v, 64'd44);

    // Most negative inputs
    clear_frame();
    y0_a[0] = 32'sh8000_0000; y1_a[0] = 32'sh8000_0000;
    y2_a[0] = 32'sh7FFF_FFFF; y3_a[0] = 32'sh8000_0000;
    start_frame();
    finish_frame("ext", 1'b0);
    idle_inputs();
    read_bin(0, v); check("ext_bin0", v, EXP_EXT0);
    read_bin(1, v); check("ext_bin1", v, EXP_EXT1);
    check("ext_cnt", 64'(bus.frame_cnt), 64'd6);

    // Reset mid-frame at beat 300
    clear_frame();
    y0_a[0] = 55;
    start_frame();
    fv_seen = 0;
    run_beats(0, 300);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle_inputs();
    check("mrst_fv", 64'(fv_seen + bus.frame_valid), 64'd0);
    check("mrst_busy", 64'(bus.busy), 64'd0);
    check("mrst_cnt", 64'(bus.frame_cnt), 64'd0);
    check("mrst_ready", 64'(bus.frame_ready), 64'd0);
    check("mrst_ovr", 64'(bus.overrun), 64'd0);
    check("mrst_rd", 64'(bus.rd_data), 64'd0);
    tick();
    check("mrst_fv_later", 64'(bus.frame_valid), 64'd0);
    clear_frame();
    y0_a[0] = 66;
    start_frame();
    finish_frame("post", 1'b0);
    check("post_cnt", 64'(bus.frame_cnt), 64'd1);
    check("post_ready", 64'(bus.frame_ready), 64'd1);
    idle_inputs();
    read_bin(0, v); check("post_bin0", v, 64'd66);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
